// File: rtl/cpu_bus_pkg.sv
// Shared types and default geometry for the CPU byte-serial memory bus unit.
package cpu_bus_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 24;
  localparam int unsigned DEF_MAX_BYTES   = 3;
  localparam int unsigned DEF_WAIT_STATES = 0;
  localparam int unsigned BANK_BITS       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_bus_addr_inc.sv
// Next byte address: either linear, or wrapping inside the current 64 KiB bank.
module cpu_bus_addr_inc
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  bank_wrap,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  always_comb begin
    next_addr = addr + ADDR_WIDTH'(1);
    if (bank_wrap) begin
      next_addr = {addr[ADDR_WIDTH-1:BANK_BITS], addr[BANK_BITS-1:0] + BANK_BITS'(1)};
    end
  end

endmodule

// File: rtl/cpu_bus_unit.sv
// Splits a multi-byte CPU request into byte slots on an 8-bit memory bus and
// returns a fixed-latency completion pulse with assembled little-endian read data.
module cpu_bus_unit
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_BYTES   = DEF_MAX_BYTES,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [$clog2(MAX_BYTES+1)-1:0] req_len,
  input  logic                           req_bank_wrap,
  input  logic [8*MAX_BYTES-1:0]         req_wdata,
  output logic                           rsp_valid,
  output logic [8*MAX_BYTES-1:0]         rsp_rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [7:0]                     mem_wdata,
  input  logic [7:0]                     mem_rdata
);

  localparam int unsigned LEN_W  = $clog2(MAX_BYTES + 1);
  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam int unsigned WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
  logic [LEN_W-1:0]    idx_q, idx_d, last_q, last_d, cap_idx_q, cap_idx_d, len_eff;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                write_q, write_d, wrap_q, wrap_d, cap_q, cap_d, slot_end;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;

  cpu_bus_addr_inc #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_inc (
    .addr      (addr_q),
    .bank_wrap (wrap_q),
    .next_addr (addr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      wait_q    <= '0;
      write_q   <= 1'b0;
      wrap_q    <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      write_q   <= write_d;
      wrap_q    <= wrap_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cap_q     <= cap_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wait_d    = wait_q;
    write_d   = write_q;
    wrap_d    = wrap_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cap_d     = 1'b0;
    cap_idx_d = cap_idx_q;

    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    mem_en    = (state_q == SLOT);
    mem_we    = (state_q == SLOT) && write_q;
    mem_addr  = (state_q == SLOT) ? addr_q : '0;
    mem_wdata = '0;
    rsp_rdata = rdata_q;

    slot_end = (32'(wait_q) == WAIT_STATES);

    if (req_len == '0)                 len_eff = LEN_W'(1);
    else if (32'(req_len) > MAX_BYTES) len_eff = LEN_W'(MAX_BYTES);
    else                               len_eff = req_len;

    // Read byte k arrives the cycle after slot k ends; the final byte is
    // forwarded straight to rsp_rdata during DONE so the fixed latency holds.
    for (int k = 0; k < int'(MAX_BYTES); k++) begin
      if (cap_q && !write_q && cap_idx_q == LEN_W'(k)) begin
        rdata_d[8*k +: 8] = mem_rdata;
        if (state_q == DONE) rsp_rdata[8*k +: 8] = mem_rdata;
      end
      if (state_q == SLOT && idx_q == LEN_W'(k)) mem_wdata = wdata_q[8*k +: 8];
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SLOT;
          addr_d  = req_addr;
          idx_d   = '0;
          last_d  = len_eff - LEN_W'(1);
          wait_d  = '0;
          write_d = req_write;
          wrap_d  = req_bank_wrap;
          wdata_d = req_wdata;
          rdata_d = '0;
        end
      end
      SLOT: begin
        if (slot_end) begin
          cap_d     = 1'b1;
          cap_idx_d = idx_q;
          wait_d    = '0;
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + LEN_W'(1);
            addr_d = addr_next;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Directed bench: one zero-wait-state unit and one two-wait-state unit sharing request fields.
module tb_cpu_bus_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid0, req_valid2;
  logic        req_ready0, req_ready2;
  logic        req_write;
  logic [23:0] req_addr;
  logic [1:0]  req_len;
  logic        req_bank_wrap;
  logic [23:0] req_wdata;
  logic        rsp_valid0, rsp_valid2;
  logic [23:0] rsp_rdata0, rsp_rdata2;
  logic        mem_en0, mem_en2, mem_we0, mem_we2;
  logic [23:0] mem_addr0, mem_addr2;
  logic [7:0]  mem_wdata0, mem_wdata2;
  logic [7:0]  mem_rdata0 = 8'h00;
  logic [7:0]  mem_rdata2 = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_bus_unit #(.ADDR_WIDTH(24), .MAX_BYTES(3), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .req_bank_wrap(req_bank_wrap), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  cpu_bus_unit #(.ADDR_WIDTH(24), .MAX_BYTES(3), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .req_bank_wrap(req_bank_wrap), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  // Test RAM contents: a few fixed bytes, everything else a simple address hash.
  function automatic logic [7:0] ram_byte(input logic [23:0] a);
    case (a)
      24'h12FFFF: return 8'hAB;
      24'h120000: return 8'hCD;
      24'h130000: return 8'hEF;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en0 && !mem_we0) mem_rdata0 <= ram_byte(mem_addr0);
    if (mem_en2 && !mem_we2) mem_rdata2 <= ram_byte(mem_addr2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic bus0(input string tag, input logic r, input logic v, input logic e,
                      input logic w, input logic [23:0] a);
    chk({tag, ".ready"}, 32'(req_ready0), 32'(r));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid0), 32'(v));
    chk({tag, ".mem_en"}, 32'(mem_en0), 32'(e));
    chk({tag, ".mem_we"}, 32'(mem_we0), 32'(w));
    chk({tag, ".mem_addr"}, 32'(mem_addr0), 32'(a));
  endtask

  initial begin
    rst = 1'b1; req_valid0 = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_len = '0; req_bank_wrap = 1'b0; req_wdata = '0;
    tick(); tick();
    bus0("reset", 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("reset.rdata", 32'(rsp_rdata0), 32'h0);
    chk("reset.wdata", 32'(mem_wdata0), 32'h0);
    chk("reset.ready2", 32'(req_ready2), 32'h1);
    rst = 1'b0;
    tick();

    // Bank-wrapping 2-byte read across 0x12FFFF
    req_valid0 = 1'b1; req_write = 1'b0; req_addr = 24'h12FFFF; req_len = 2'd2; req_bank_wrap = 1'b1;
    tick();
    req_valid0 = 1'b0; req_addr = 24'h0000AA; req_len = 2'd1; req_bank_wrap = 1'b0;
    bus0("wrap.c1", 1'b0, 1'b0, 1'b1, 1'b0, 24'h12FFFF);
    tick(); bus0("wrap.c2", 1'b0, 1'b0, 1'b1, 1'b0, 24'h120000);
    tick(); bus0("wrap.c3", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("wrap.rdata", 32'(rsp_rdata0), 32'h00CDAB);
    tick(); bus0("wrap.c4", 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("wrap.rdata_hold", 32'(rsp_rdata0), 32'h00CDAB);

    // Same read, linear increment
    req_valid0 = 1'b1; req_addr = 24'h12FFFF; req_len = 2'd2; req_bank_wrap = 1'b0;
    tick();
    req_valid0 = 1'b0; req_bank_wrap = 1'b1;
    bus0("lin.c1", 1'b0, 1'b0, 1'b1, 1'b0, 24'h12FFFF);
    tick(); bus0("lin.c2", 1'b0, 1'b0, 1'b1, 1'b0, 24'h130000);
    tick(); bus0("lin.c3", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("lin.rdata", 32'(rsp_rdata0), 32'h00EFAB);
    tick();

    // req_len=0 write behaves as one byte
    req_valid0 = 1'b1; req_write = 1'b1; req_addr = 24'h000100; req_len = 2'd0;
    req_bank_wrap = 1'b0; req_wdata = 24'h998877;
    tick();
    req_valid0 = 1'b0; req_wdata = 24'h000000;
    bus0("len0.c1", 1'b0, 1'b0, 1'b1, 1'b1, 24'h000100);
    chk("len0.wdata", 32'(mem_wdata0), 32'h77);
    chk("len0.rdata_clr", 32'(rsp_rdata0), 32'h0);
    tick(); bus0("len0.c2", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("len0.rdata", 32'(rsp_rdata0), 32'h0);
    tick();

    // Oversized length (7 truncated to the 2-bit port) clamps to 3 bytes
    req_valid0 = 1'b1; req_write = 1'b0; req_addr = 24'h000040; req_len = 2'(3'd7);
    tick();
    req_valid0 = 1'b0;
    bus0("len7.c1", 1'b0, 1'b0, 1'b1, 1'b0, 24'h000040);
    tick(); bus0("len7.c2", 1'b0, 1'b0, 1'b1, 1'b0, 24'h000041);
    tick(); bus0("len7.c3", 1'b0, 1'b0, 1'b1, 1'b0, 24'h000042);
    tick(); bus0("len7.c4", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("len7.rdata", 32'(rsp_rdata0), 32'h181B1A);
    tick();

    // Back-to-back with req_valid held high
    req_valid0 = 1'b1; req_addr = 24'h000050; req_len = 2'd1;
    tick(); bus0("b2b.c1", 1'b0, 1'b0, 1'b1, 1'b0, 24'h000050);
    tick(); bus0("b2b.c2", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("b2b.rdata", 32'(rsp_rdata0), 32'h00000A);
    tick(); bus0("b2b.c3", 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    tick(); bus0("b2b.c4", 1'b0, 1'b0, 1'b1, 1'b0, 24'h000050);
    req_valid0 = 1'b0;
    tick(); bus0("b2b.c5", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    tick();

    // Reset during the second slot of a 3-byte read
    req_valid0 = 1'b1; req_addr = 24'h000060; req_len = 2'd3;
    tick();
    req_valid0 = 1'b0;
    bus0("abort.c1", 1'b0, 1'b0, 1'b1, 1'b0, 24'h000060);
    tick(); bus0("abort.c2", 1'b0, 1'b0, 1'b1, 1'b0, 24'h000061);
    rst = 1'b1;
    #1;
    bus0("abort.rst", 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("abort.rdata", 32'(rsp_rdata0), 32'h0);
    tick();
    rst = 1'b0;
    req_valid0 = 1'b1; req_addr = 24'h000070; req_len = 2'd1;
    #1;
    bus0("abort.c0", 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    tick();
    req_valid0 = 1'b0;
    bus0("after.c1", 1'b0, 1'b0, 1'b1, 1'b0, 24'h000070);
    tick(); bus0("after.c2", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    chk("after.rdata", 32'(rsp_rdata0), 32'h00002A);
    tick();

    // Two-wait-state 3-byte write
    req_valid2 = 1'b1; req_write = 1'b1; req_addr = 24'h000010; req_len = 2'd3;
    req_bank_wrap = 1'b0; req_wdata = 24'h332211;
    tick();
    req_valid2 = 1'b0; req_wdata = 24'hFFFFFF;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("ws2.c%0d.en", c), 32'(mem_en2), 32'h1);
      chk($sformatf("ws2.c%0d.we", c), 32'(mem_we2), 32'h1);
      chk($sformatf("ws2.c%0d.addr", c), 32'(mem_addr2), 32'h10 + 32'((c - 1) / 3));
      chk($sformatf("ws2.c%0d.wdata", c), 32'(mem_wdata2), 32'h11 * 32'((c - 1) / 3 + 1));
      chk($sformatf("ws2.c%0d.rsp_valid", c), 32'(rsp_valid2), 32'h0);
      tick();
    end
    chk("ws2.c10.rsp_valid", 32'(rsp_valid2), 32'h1);
    chk("ws2.c10.en", 32'(mem_en2), 32'h0);
    chk("ws2.c10.rdata", 32'(rsp_rdata2), 32'h0);
    tick();
    chk("ws2.c11.ready", 32'(req_ready2), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
